// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Holds the FSM state encoding and the stream framing constants.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_e;

  localparam int CNT_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects big-endian bytes into a 32-bit instruction word.
// Flags the shift that completes a word and exposes the word it produces.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_next,
  output logic              word_done
);

  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;

  assign word_next = {shift_q[WORD_W-9:0], byte_in};
  assign word_done = shift_en && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    if (clear) begin
      byte_cnt_d = 2'd0;
    end else if (shift_en) begin
      shift_d    = word_next;
      byte_cnt_d = word_done ? 2'd0 : byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q <= 2'd0;
      shift_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a count-prefixed byte stream into program memory one word at a time,
// holding the CPU in reset while the load is in progress.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        index_q, index_d;
  logic [DATA_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic                    xfer;
  logic                    asm_clear;
  logic                    asm_shift;
  logic [WORD_W-1:0]       asm_word;
  logic                    asm_done;
  logic [CNT_W-1:0]        cnt_full;
  logic [CNT_W-1:0]        idx_inc;

  assign xfer      = ByteValid && ByteReady;
  assign asm_shift = xfer && (state_q == DATA);
  assign cnt_full  = {count_q[CNT_W-1:8], ByteIn};
  assign idx_inc   = index_q + CNT_W'(1);

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (ByteIn),
    .word_next (asm_word),
    .word_done (asm_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      waddr_q <= BASE_ADDRESS;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    index_d   = index_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    asm_clear = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (Start) begin
          state_d   = CNT_HI;
          count_d   = '0;
          index_d   = '0;
          asm_clear = 1'b1;
        end
      end
      CNT_HI: begin
        if (xfer) begin
          count_d = {ByteIn, 8'h00};
          state_d = CNT_LO;
        end
      end
      CNT_LO: begin
        if (xfer) begin
          count_d = cnt_full;
          if (cnt_full == '0)                          state_d = DONE;
          else if (cnt_full > CNT_W'(MEMORY_DEPTH))    state_d = ERROR;
          else                                         state_d = DATA;
        end
      end
      DATA: begin
        // Latch the write port on the completing byte so it is stable for the whole WRITE cycle.
        if (asm_done) begin
          wdata_d = DATA_WIDTH'(asm_word);
          waddr_d = BASE_ADDRESS + (DATA_WIDTH'(index_q) << 2);
          state_d = WRITE;
        end
      end
      WRITE: begin
        index_d = idx_inc;
        state_d = (idx_inc == count_q) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ByteReady   = 1'b0;
    CpuHold     = 1'b0;
    WriteEnable = 1'b0;
    Done        = 1'b0;
    Error       = 1'b0;
    case (state_q)
      CNT_HI, CNT_LO, DATA: begin
        ByteReady = 1'b1;
        CpuHold   = 1'b1;
      end
      WRITE: begin
        CpuHold     = 1'b1;
        WriteEnable = 1'b1;
      end
      DONE:    Done  = 1'b1;
      ERROR:   Error = 1'b1;
      default: ;
    endcase
  end

  assign WriteAddress = waddr_q;
  assign WriteData    = wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  int          wr_n = 0;
  int          base_n;

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .ByteIn       (ByteIn),
    .ByteValid    (ByteValid),
    .ByteReady    (ByteReady),
    .WriteEnable  (WriteEnable),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .CpuHold      (CpuHold),
    .Done         (Done),
    .Error        (Error)
  );

  always #5 clk = ~clk;

  // Memory-side log of every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (WriteEnable) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = WriteAddress;
        wr_data[wr_n] = WriteData;
      end
      wr_n = wr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    ByteIn    = b;
    ByteValid = 1'b1;
    while (!ByteReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!ByteReady) chk("byte_ready_timeout", 32'(ByteReady), 32'd1);
    @(negedge clk);
    ByteValid = 1'b0;
  endtask

  task automatic send_byte_gap(input logic [7:0] b);
    int gaps = $urandom_range(0, 3);
    repeat (gaps) begin
      ByteValid = 1'b0;
      ByteIn    = 8'($urandom);
      @(negedge clk);
    end
    send_byte(b);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    Start     = 1'b0;
    ByteIn    = 8'h00;
    ByteValid = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_byte_ready", 32'(ByteReady), 32'd0);
    chk("rst_we",         32'(WriteEnable), 32'd0);
    chk("rst_cpu_hold",   32'(CpuHold), 32'd0);
    chk("rst_done",       32'(Done), 32'd0);
    chk("rst_error",      32'(Error), 32'd0);
    chk("rst_waddr",      WriteAddress, 32'h0040_0000);
    chk("rst_wdata",      WriteData, 32'h0);
    reset = 1'b0;

    // Bytes offered while idle must be ignored.
    ByteValid = 1'b1;
    ByteIn    = 8'hFF;
    repeat (3) @(negedge clk);
    ByteValid = 1'b0;
    chk("idle_no_hold", 32'(CpuHold), 32'd0);

    // Two-word load.
    pulse_start();
    chk("t1_ready", 32'(ByteReady), 32'd1);
    chk("t1_hold",  32'(CpuHold), 32'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h24); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    chk("t1_we_latency", 32'(WriteEnable), 32'd1);
    chk("t1_wdata0_live", WriteData, 32'h2408_0005);
    send_byte(8'h20); send_byte(8'h09); send_byte(8'h00); send_byte(8'h07);
    chk("t1_we_latency2", 32'(WriteEnable), 32'd1);
    @(negedge clk);
    chk("t1_done",  32'(Done), 32'd1);
    chk("t1_hold_off", 32'(CpuHold), 32'd0);
    chk("t1_we_off", 32'(WriteEnable), 32'd0);
    chk("t1_wr_n",  32'(wr_n), 32'd2);
    chk("t1_addr0", wr_addr[0], 32'h0040_0000);
    chk("t1_data0", wr_data[0], 32'h2408_0005);
    chk("t1_addr1", wr_addr[1], 32'h0040_0004);
    chk("t1_data1", wr_data[1], 32'h2009_0007);
    chk("t1_wdata_hold", WriteData, 32'h2009_0007);
    chk("t1_waddr_hold", WriteAddress, 32'h0040_0004);

    // Bytes offered in DONE are not consumed.
    ByteValid = 1'b1;
    ByteIn    = 8'h55;
    repeat (3) @(negedge clk);
    ByteValid = 1'b0;
    chk("done_sticky", 32'(Done), 32'd1);

    // Zero count.
    base_n = wr_n;
    pulse_start();
    chk("t2_done_cleared", 32'(Done), 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    chk("t2_hold_off", 32'(CpuHold), 32'd0);
    chk("t2_done", 32'(Done), 32'd1);
    chk("t2_no_write", 32'(wr_n), 32'(base_n));

    // Count over depth.
    pulse_start();
    send_byte(8'h00); send_byte(8'h21);
    chk("t3_error", 32'(Error), 32'd1);
    chk("t3_done", 32'(Done), 32'd0);
    chk("t3_ready_off", 32'(ByteReady), 32'd0);
    @(negedge clk);
    chk("t3_error_sticky", 32'(Error), 32'd1);
    chk("t3_no_write", 32'(wr_n), 32'(base_n));

    // Count exactly at depth is accepted, then aborted mid-word by reset.
    pulse_start();
    chk("t4_error_cleared", 32'(Error), 32'd0);
    send_byte(8'h00); send_byte(8'h20);
    chk("t4_depth_ok", 32'(Error), 32'd0);
    chk("t4_in_data", 32'(ByteReady), 32'd1);
    send_byte(8'hAA); send_byte(8'hBB);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_rst_hold", 32'(CpuHold), 32'd0);
    chk("t4_rst_ready", 32'(ByteReady), 32'd0);
    chk("t4_rst_waddr", WriteAddress, 32'h0040_0000);
    chk("t4_rst_wdata", WriteData, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("t4_no_write", 32'(wr_n), 32'(base_n));
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk);
    chk("t4_done", 32'(Done), 32'd1);
    chk("t4_wr_n", 32'(wr_n), 32'(base_n + 1));
    chk("t4_addr", wr_addr[base_n], 32'h0040_0000);
    chk("t4_data", wr_data[base_n], 32'h1122_3344);

    // ByteValid toggling with idle gaps.
    base_n = wr_n;
    pulse_start();
    send_byte_gap(8'h00); send_byte_gap(8'h01);
    send_byte_gap(8'h8C); send_byte_gap(8'h42); send_byte_gap(8'h00); send_byte_gap(8'h10);
    repeat (4) @(negedge clk);
    chk("t5_done", 32'(Done), 32'd1);
    chk("t5_wr_n", 32'(wr_n), 32'(base_n + 1));
    chk("t5_addr", wr_addr[base_n], 32'h0040_0000);
    chk("t5_data", wr_data[base_n], 32'h8C42_0010);

    // Start held high throughout a one-word load.
    base_n = wr_n;
    Start = 1'b1;
    @(negedge clk);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD);
    chk("t6_busy_hold", 32'(CpuHold), 32'd1);
    send_byte(8'hBE); send_byte(8'hEF);
    chk("t6_we", 32'(WriteEnable), 32'd1);
    @(negedge clk);
    chk("t6_done", 32'(Done), 32'd1);
    chk("t6_wr_n", 32'(wr_n), 32'(base_n + 1));
    chk("t6_data", wr_data[base_n], 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t6_restart_done", 32'(Done), 32'd0);
    chk("t6_restart_ready", 32'(ByteReady), 32'd1);
    chk("t6_restart_hold", 32'(CpuHold), 32'd1);
    Start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_final_idle", 32'(CpuHold), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEMORY_DEPTH, default 32, is the number of instruction words in program memory.
REQ-002 Parameter DATA_WIDTH, default 32, is the instruction and address width.
REQ-003 Parameter BASE_ADDRESS, default 32'h0040_0000, is the byte address of word 0.
REQ-004 Port clk, input, 1, is the single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1, is the synchronous, active-high reset.
REQ-006 Port Start, input, 1, is a level request to begin a load.
REQ-007 Port ByteIn, input, 8, is the incoming program byte.
REQ-008 Port ByteValid, input, 1, means ByteIn holds a valid byte.
REQ-009 Port ByteReady, output, 1, means the loader accepts ByteIn this cycle.
REQ-010 Port WriteEnable, output, 1, is the memory write strobe.
REQ-011 Port WriteAddress, output, DATA_WIDTH, is the byte address of the word being written.
REQ-012 Port WriteData, output, DATA_WIDTH, is the instruction word being written.
REQ-013 Port CpuHold, output, 1, holds the processor in reset while a load is in progress.
REQ-014 Port Done, output, 1, means the last load completed.
REQ-015 Port Error, output, 1, means the last load was rejected.

Function
REQ-016 A byte transfers only on a rising edge where ByteValid and ByteReady are both 1.
REQ-017 The FSM states SHALL be IDLE, CNT_HI, CNT_LO, DATA, WRITE, DONE and ERROR.
- ByteReady = 1 only in CNT_HI, CNT_LO and DATA.
- CpuHold = 1 in CNT_HI, CNT_LO, DATA and WRITE.
REQ-018 From IDLE, DONE or ERROR, Start = 1 goes to CNT_HI, clears Done, Error and the word index; Start is ignored in all other states.
REQ-019 The stream SHALL be a 16-bit big-endian word count: the high byte is taken in CNT_HI and the low byte in CNT_LO.
- Then a count of words, each 4 bytes, most-significant byte first.
REQ-020 In CNT_LO on transfer:
- count = 0 -> DONE.
- count > MEMORY_DEPTH -> ERROR.
- otherwise -> DATA.
REQ-021 In DATA, bytes shift into a 32-bit assembly register; on the 4th transfer -> WRITE.
REQ-022 In WRITE, WriteEnable = 1 for exactly one cycle, with:
- WriteData = the assembled word.
- WriteAddress = BASE_ADDRESS + 4*index, with DATA_WIDTH wrap-around.
REQ-023 After WRITE, index increments; if index+1 = count -> DONE, otherwise -> DATA.
REQ-024 Latency: WriteEnable asserts in the cycle after the 4th byte's transfer edge; the minimum is 5 cycles per word.
REQ-025 DONE asserts Done = 1 and ERROR asserts Error = 1; both hold until the next Start or reset.
REQ-026 WriteAddress and WriteData hold their last values outside WRITE; WriteEnable = 0 outside WRITE.
REQ-027 Bytes offered while ByteReady = 0 are not consumed, and no byte is ever consumed twice.

Reset
REQ-028 On reset = 1 at a clock edge:
- State -> IDLE.
- ByteReady, WriteEnable, CpuHold, Done and Error -> 0.
- WriteAddress -> BASE_ADDRESS.
- WriteData, index, count and the byte counter -> 0.
REQ-029 Reset mid-load aborts immediately; no further write is issued, and already-written words remain in memory.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the 16-bit count width, and the 4-bytes-per-word constant.
REQ-031 One sub-module, word_assembler, SHALL hold the byte counter and shift register and flag word completion.
REQ-032 The write port SHALL match the program memory address convention: byte address, word-aligned, index = (address - BASE_ADDRESS)[..:2].

Verification
REQ-033 Start, then stream 00 02 | 24 08 00 05 | 20 09 00 07 -> two writes, then Done = 1:
- 32'h2408_0005 @ 32'h0040_0000.
- 32'h2009_0007 @ 32'h0040_0004.
REQ-034 Count 00 00 -> DONE with no WriteEnable pulse; CpuHold falls the cycle after the CNT_LO transfer.
REQ-035 Count 00 21 (33 > 32) -> Error = 1, no write, ByteReady = 0 afterwards.
REQ-036 ByteValid toggling randomly with 1 word 8C 42 00 10 -> exactly one write of 32'h8C42_0010; no byte is lost or duplicated.
REQ-037 reset = 1 after 2 of 4 data bytes, then a fresh load of 1 word -> only the new word is written, at the base address.
REQ-038 Start held high through a load of count 00 01 -> no restart while busy; a new load begins the cycle after DONE.
